// File: rtl/alu_compare_unit.sv
// RV32I execute datapath: 32-bit ALU plus branch comparator with an EX->MEM output register.
// Define ALU_MUL_EN to enable alu_op 11 (MUL, low 32 bits of the product).
module alu_compare_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [3:0]  alu_op,
  input  logic [31:0] cmp_in1,
  input  logic [31:0] cmp_in2,
  input  logic [2:0]  funct3,
  input  logic        in_valid,
  output logic [31:0] result,
  output logic        cond,
  output logic [31:0] result_q,
  output logic        cond_q,
  output logic        valid_q
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpSll  = 4'd2;
  localparam logic [3:0] OpSlt  = 4'd3;
  localparam logic [3:0] OpSltu = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpOr   = 4'd8;
  localparam logic [3:0] OpAnd  = 4'd9;
  localparam logic [3:0] OpPass = 4'd10;
  localparam logic [3:0] OpMul  = 4'd11;

  localparam logic [2:0] BrEq  = 3'b000;
  localparam logic [2:0] BrNe  = 3'b001;
  localparam logic [2:0] BrLt  = 3'b100;
  localparam logic [2:0] BrGe  = 3'b101;
  localparam logic [2:0] BrLtu = 3'b110;
  localparam logic [2:0] BrGeu = 3'b111;

  logic [4:0]  shamt;
  logic        alu_lt_s;
  logic        alu_lt_u;
  logic [31:0] mul_res;

  logic        cmp_eq;
  logic        cmp_lt_s;
  logic        cmp_lt_u;

  logic [31:0] result_d;
  logic        cond_d;

  // Shift amount comes only from the low five bits of operand B.
  assign shamt    = in2[4:0];
  assign alu_lt_s = $signed(in1) < $signed(in2);
  assign alu_lt_u = in1 < in2;

`ifdef ALU_MUL_EN
  assign mul_res = in1 * in2;
`else
  assign mul_res = 32'd0;
`endif

  always_comb begin
    result_d = 32'd0;
    case (alu_op)
      OpAdd:   result_d = in1 + in2;
      OpSub:   result_d = in1 - in2;
      OpSll:   result_d = in1 << shamt;
      OpSlt:   result_d = {31'd0, alu_lt_s};
      OpSltu:  result_d = {31'd0, alu_lt_u};
      OpXor:   result_d = in1 ^ in2;
      OpSrl:   result_d = in1 >> shamt;
      OpSra:   result_d = $unsigned($signed(in1) >>> shamt);
      OpOr:    result_d = in1 | in2;
      OpAnd:   result_d = in1 & in2;
      OpPass:  result_d = in2;
      OpMul:   result_d = mul_res;
      default: result_d = 32'd0;
    endcase
  end

  assign cmp_eq   = cmp_in1 == cmp_in2;
  assign cmp_lt_s = $signed(cmp_in1) < $signed(cmp_in2);
  assign cmp_lt_u = cmp_in1 < cmp_in2;

  always_comb begin
    cond_d = 1'b0;
    case (funct3)
      BrEq:    cond_d = cmp_eq;
      BrNe:    cond_d = ~cmp_eq;
      BrLt:    cond_d = cmp_lt_s;
      BrGe:    cond_d = ~cmp_lt_s;
      BrLtu:   cond_d = cmp_lt_u;
      BrGeu:   cond_d = ~cmp_lt_u;
      default: cond_d = 1'b0;
    endcase
  end

  assign result = result_d;
  assign cond   = cond_d;

  // Loads every cycle; no stall path at this boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'd0;
      cond_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      cond_q   <= cond_d;
      valid_q  <= in_valid;
    end
  end

endmodule

// File: tb/tb_alu_compare_unit.sv
// Randomized self-checking bench for alu_compare_unit against an arithmetic reference model.
module tb_alu_compare_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [3:0]  alu_op;
  logic [31:0] cmp_in1;
  logic [31:0] cmp_in2;
  logic [2:0]  funct3;
  logic        in_valid;
  logic [31:0] result;
  logic        cond;
  logic [31:0] result_q;
  logic        cond_q;
  logic        valid_q;

  int checks   = 0;
  int failures = 0;

  alu_compare_unit u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in1      (in1),
    .in2      (in2),
    .alu_op   (alu_op),
    .cmp_in1  (cmp_in1),
    .cmp_in2  (cmp_in2),
    .funct3   (funct3),
    .in_valid (in_valid),
    .result   (result),
    .cond     (cond),
    .result_q (result_q),
    .cond_q   (cond_q),
    .valid_q  (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam longint unsigned Two32 = 64'h1_0000_0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    int              sh = int'(b % 32);
    longint unsigned r  = 0;
    logic [31:0]     v;
    case (op)
      4'd0: r = (ua + ub) % Two32;
      4'd1: r = (ua + Two32 - ub) % Two32;
      4'd2: r = (ua * (64'd1 << sh)) % Two32;
      4'd3: r = (sa < sb) ? 1 : 0;
      4'd4: r = (ua < ub) ? 1 : 0;
      4'd5: r = a ^ b;
      4'd6: r = ua / (64'd1 << sh);
      4'd7: begin
        // Repeated halving that keeps the sign bit.
        v = a;
        for (int i = 0; i < sh; i++) v = {v[31], v[31:1]};
        r = v;
      end
      4'd8: r = a | b;
      4'd9: r = a & b;
      4'd10: r = ub;
`ifdef ALU_MUL_EN
      4'd11: r = (ua * ub) % Two32;
`endif
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic logic model_cond(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = a;
    longint unsigned ub = b;
    case (f)
      3'b000:  return ua == ub;
      3'b001:  return ua != ub;
      3'b100:  return sa < sb;
      3'b101:  return sa >= sb;
      3'b110:  return ua < ub;
      3'b111:  return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  // Apply one vector, check combinational outputs, clock it, check the registered copy.
  task automatic apply(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f, input logic [31:0] ca,
                       input logic [31:0] cb, input logic v);
    logic [31:0] exp_r;
    logic        exp_c;
    alu_op = op; in1 = a; in2 = b; funct3 = f; cmp_in1 = ca; cmp_in2 = cb; in_valid = v;
    exp_r = model_alu(op, a, b);
    exp_c = model_cond(f, ca, cb);
    #1;
    check_eq({tag, ".result"}, result, exp_r);
    check_eq({tag, ".cond"}, {31'd0, cond}, {31'd0, exp_c});
    @(posedge clk);
    #1;
    check_eq({tag, ".result_q"}, result_q, exp_r);
    check_eq({tag, ".cond_q"}, {31'd0, cond_q}, {31'd0, exp_c});
    check_eq({tag, ".valid_q"}, {31'd0, valid_q}, {31'd0, v});
  endtask

  initial begin
    logic [31:0] a, b, ca, cb;
    rst_n = 1'b0; in1 = 0; in2 = 0; alu_op = 0; cmp_in1 = 0; cmp_in2 = 0; funct3 = 0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("reset.result_q", result_q, 32'd0);
    check_eq("reset.cond_q", {31'd0, cond_q}, 32'd0);
    check_eq("reset.valid_q", {31'd0, valid_q}, 32'd0);
    rst_n = 1'b1;

    apply("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 3'b000, 0, 0, 1'b1);
    apply("sub_wrap", 4'd1, 32'd0, 32'd1, 3'b000, 0, 0, 1'b1);
    apply("sra", 4'd7, 32'h8000_0000, 32'h21, 3'b000, 0, 0, 1'b1);
    apply("srl", 4'd6, 32'h8000_0000, 32'h21, 3'b000, 0, 0, 1'b0);
    apply("sll", 4'd2, 32'd1, 32'h21, 3'b000, 0, 0, 1'b1);
    apply("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 3'b000, 0, 0, 1'b1);
    apply("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 3'b000, 0, 0, 1'b1);
    apply("pass", 4'd10, 32'hDEAD_BEEF, 32'h1234_5000, 3'b000, 0, 0, 1'b1);
    apply("op15", 4'd15, 32'h1234_5678, 32'h1, 3'b000, 0, 0, 1'b1);
    apply("mul", 4'd11, 32'hFFFF_FFFF, 32'd3, 3'b000, 0, 0, 1'b1);
    check_eq("sra_const", model_alu(4'd7, 32'h8000_0000, 32'h21), 32'hC000_0000);
    for (int f = 0; f < 8; f++)
      apply($sformatf("br%0d", f), 4'd0, 32'd0, 32'd0, 3'(f), 32'hFFFF_FFFE, 32'd2, 1'b1);
    for (int f = 0; f < 8; f++)
      apply($sformatf("br_eq%0d", f), 4'd0, 32'd0, 32'd0, 3'(f), 32'h8000_0000,
            32'h8000_0000, 1'b0);

    // Registered stage and asynchronous reset mid-cycle.
    apply("regload", 4'd0, 32'd3, 32'd4, 3'b001, 32'd1, 32'd2, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async.result_q", result_q, 32'd0);
    check_eq("async.cond_q", {31'd0, cond_q}, 32'd0);
    check_eq("async.valid_q", {31'd0, valid_q}, 32'd0);
    check_eq("async.result", result, 32'd7);
    @(posedge clk); #1;
    check_eq("held.valid_q", {31'd0, valid_q}, 32'd0);
    rst_n = 1'b1;
    apply("post_reset", 4'd1, 32'd10, 32'd3, 3'b110, 32'd1, 32'd2, 1'b1);

    for (int i = 0; i < 400; i++) begin
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      ca = $urandom;
      cb = ($urandom_range(0, 3) == 0) ? ca : $urandom;
      if ($urandom_range(0, 4) == 0) cb = {~ca[31], ca[30:0]};
      apply($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), a, b,
            3'($urandom_range(0, 7)), ca, cb, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
